cache_mem_arbiter: RTL and testbench

- Shares one main-memory port between the instruction-cache and data-cache controllers.
- Sequences each granted miss as a multi-word block fill, or each write as a single-word write-through.
- Generates the per-requester ready that releases the cache controller's stall.
- Sits between both cache controllers and main memory.

---
 rtl/cache_mem_arbiter_if.sv | 47 ++++
 rtl/cache_mem_arbiter.sv | 117 +++++++++++
 tb/tb_cache_mem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of both cache-controller request ports, the fill bus and the memory port.
// The arbiter uses the master modport; caches and memory use the slave modport.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4
);
  localparam int IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  logic              req0_rd;
  logic              req0_wr;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req1_rd;
  logic              req1_wr;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              fill_we;
  logic              fill_sel;
  logic [IDX_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req0_rd, req0_wr, req0_addr, req0_wdata,
    input  req1_rd, req1_wr, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req1_ready,
    output fill_we, fill_sel, fill_idx, fill_data,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req0_rd, req0_wr, req0_addr, req0_wdata,
    output req1_rd, req1_wr, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req1_ready,
    input  fill_we, fill_sel, fill_idx, fill_data,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin share of one memory port between icache and dcache: block fills for reads,
// single-word write-through for writes; ready pulses one cycle after the access completes.
module cache_mem_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int MEM_LAT     = 4
) (
  input  logic clk,
  input  logic reset,
  cache_mem_arbiter_if.master bus
);
  localparam int IDX_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gnt_q, gnt_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [IDX_W-1:0]  word_q, word_d;
  logic [LAT_W-1:0]  lat_q, lat_d;

  logic              act0, act1, sel;
  logic              sel_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic              last_lat, last_word, in_acc, fill_fire;

  assign act0      = bus.req0_rd | bus.req0_wr;
  assign act1      = bus.req1_rd | bus.req1_wr;
  assign sel       = (act0 & act1) ? rr_q : act1;
  assign sel_rd    = sel ? bus.req1_rd : bus.req0_rd;
  assign sel_addr  = sel ? bus.req1_addr : bus.req0_addr;
  assign last_lat  = (lat_q == LAT_W'(MEM_LAT - 1));
  assign last_word = (word_q == IDX_W'(BLOCK_WORDS - 1));
  assign in_acc    = (state_q == ACCESS);
  assign fill_fire = in_acc & rd_q & last_lat;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (act0 | act1) begin
          gnt_d   = sel;
          rd_d    = sel_rd;
          // Reads fetch the whole line, so start from its first word.
          addr_d  = sel_rd ? (sel_addr & ~OFF_MASK) : sel_addr;
          wdata_d = sel ? bus.req1_wdata : bus.req0_wdata;
          word_d  = '0;
          lat_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        lat_d = lat_q + 1'b1;
        if (last_lat) begin
          lat_d = '0;
          if (rd_q && !last_word) begin
            word_d = word_q + 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // No arbitration here: a requester dropping on ready must not be re-granted.
        rr_d    = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      lat_q   <= lat_d;
    end
  end

  assign bus.mem_en     = in_acc;
  assign bus.mem_we     = in_acc & ~rd_q;
  assign bus.mem_addr   = rd_q ? (addr_q + ADDR_W'(word_q)) : addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.fill_we    = fill_fire;
  assign bus.fill_sel   = fill_fire & gnt_q;
  assign bus.fill_idx   = fill_fire ? word_q : '0;
  assign bus.fill_data  = bus.mem_rdata;
  assign bus.req0_ready = (state_q == DONE) & ~gnt_q;
  assign bus.req1_ready = (state_q == DONE) & gnt_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: memory returns 0xA0000000 | address on every read.
module tb_cache_mem_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  cache_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(4)) bus ();

  cache_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(4), .MEM_LAT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.mem_rdata = 32'hA000_0000 | 32'(bus.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".mem_en"},  bus.mem_en, 0);
    chk({tag, ".mem_we"},  bus.mem_we, 0);
    chk({tag, ".fill_we"}, bus.fill_we, 0);
    chk({tag, ".fill_sel"}, bus.fill_sel, 0);
    chk({tag, ".fill_idx"}, bus.fill_idx, 0);
    chk({tag, ".rdy0"},    bus.req0_ready, 0);
    chk({tag, ".rdy1"},    bus.req1_ready, 0);
  endtask

  task automatic set_req(input int id, input logic rd, input logic wr,
                         input logic [9:0] addr, input logic [31:0] wd);
    if (id == 0) begin
      bus.req0_rd = rd; bus.req0_wr = wr; bus.req0_addr = addr; bus.req0_wdata = wd;
    end else begin
      bus.req1_rd = rd; bus.req1_wr = wr; bus.req1_addr = addr; bus.req1_wdata = wd;
    end
  endtask

  // Called at a falling edge with the DUT idle; the next rising edge is the grant edge.
  // e indexes the falling edge following rising edge e after the grant.
  task automatic xact(input int id, input logic rd, input logic wr,
                      input logic [9:0] addr, input logic [31:0] wd, input int drop_e);
    int         n;
    logic [9:0] ea;
    logic       fw;
    n = rd ? 16 : 4;
    set_req(id, rd, wr, addr, wd);
    for (int e = 0; e <= n + 1; e++) begin
      @(negedge clk);
      if (e < n) begin
        ea = rd ? ((addr & 10'h3FC) + 10'(e / 4)) : addr;
        fw = rd && ((e % 4) == 3);
        chk("mem_en", bus.mem_en, 1);
        chk("mem_we", bus.mem_we, !rd);
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_wdata", bus.mem_wdata, wd);
        chk("fill_we", bus.fill_we, fw);
        if (fw) begin
          chk("fill_idx", bus.fill_idx, e / 4);
          chk("fill_sel", bus.fill_sel, id);
          chk("fill_data", bus.fill_data, 32'hA000_0000 | 32'(ea));
        end
        chk("rdy0_busy", bus.req0_ready, 0);
        chk("rdy1_busy", bus.req1_ready, 0);
      end else begin
        chk("mem_en_end", bus.mem_en, 0);
        chk("fill_we_end", bus.fill_we, 0);
        chk("rdy0_end", bus.req0_ready, (e == n) && (id == 0));
        chk("rdy1_end", bus.req1_ready, (e == n) && (id == 1));
      end
      if (e == drop_e || e == n) set_req(id, 1'b0, 1'b0, addr, wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    set_req(0, 1'b0, 1'b0, 10'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 10'h0, 32'h0);
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset.mem_addr", bus.mem_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");

    // Single block fill for the icache, then a dcache write-through.
    xact(0, 1'b1, 1'b0, 10'h387, 32'h0, -1);
    xact(1, 1'b0, 1'b1, 10'h0A5, 32'hDEAD_BEEF, -1);

    // Both requesting: rr_ptr is back at 0, so req0, req1, then req0 again.
    set_req(1, 1'b1, 1'b0, 10'h120, 32'h0);
    xact(0, 1'b1, 1'b0, 10'h010, 32'h0, -1);
    set_req(0, 1'b1, 1'b0, 10'h01B, 32'h0);
    xact(1, 1'b1, 1'b0, 10'h120, 32'h0, -1);
    xact(0, 1'b1, 1'b0, 10'h01B, 32'h0, -1);

    // Reset in cycle 9 of a fill aborts it with no ready.
    set_req(0, 1'b1, 1'b0, 10'h040, 32'h0);
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    chk("pre_abort.mem_en", bus.mem_en, 1);
    reset = 1'b1;
    #1;
    chk_quiet("abort");
    set_req(0, 1'b0, 1'b0, 10'h040, 32'h0);
    repeat (2) @(negedge clk);
    chk_quiet("abort_hold");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet("abort_after");
    end
    xact(0, 1'b1, 1'b0, 10'h043, 32'h0, -1);

    // Request dropped early still completes; rd+wr together performs the read.
    xact(1, 1'b1, 1'b0, 10'h2C3, 32'h0, 2);
    xact(0, 1'b1, 1'b1, 10'h155, 32'h1234_5678, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
